// File: rtl/pid_round_robin_scheduler.sv
// pid_round_robin_scheduler
//   Shares one PID datapath across NUM_MOTORS motor channels. A free-running
//   period counter produces the control tick; each accepted tick starts a
//   round that launches one PID evaluation per enabled motor in index order,
//   waits for the result (or gives up after TIMEOUT cycles) and writes the
//   duty value into the per-motor duty bank.
//
// Ports
//   CLK, reset       system clock, synchronous active-high reset
//   enable           1 = ticks start rounds, 0 = ticks are dropped
//   motor_enable     per-motor enable mask, captured when a round starts
//   pid_start        one-cycle launch strobe to the PID engine
//   pid_motor_id     motor under evaluation (START through WRITE, else 0)
//   pid_done         one-cycle completion strobe from the PID engine
//   pid_result       signed duty from the PID engine, valid with pid_done
//   duty_wr          one-cycle write strobe to the duty bank
//   duty_wr_id       target motor of duty_wr
//   duty_wr_data     signed duty written (0 after a timeout)
//   busy             round in progress
//   fault            sticky per-motor PID-timeout flags
//   fault_clear      pulse, clears all fault bits (a same-cycle set wins)
//   overrun          one-cycle pulse, tick arrived while busy
//   overrun_count    saturating overrun counter
//
// Handshake: pid_start/pid_done and duty_wr are single-cycle strobes with no
// back-pressure; the PID engine must accept a launch whenever pid_start is
// high, and pid_done is only honoured while a launched evaluation is pending.
module pid_round_robin_scheduler #(
    parameter int NUM_MOTORS   = 4,
    parameter int CLOCK_FREQ   = 16_000_000,
    parameter int CONTROL_FREQ = 1000,
    parameter int TIMEOUT      = 64,
    localparam int IDW = (NUM_MOTORS > 1) ? $clog2(NUM_MOTORS) : 1
) (
    input  logic                   CLK,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [NUM_MOTORS-1:0]  motor_enable,
    output logic                   pid_start,
    output logic [IDW-1:0]         pid_motor_id,
    input  logic                   pid_done,
    input  logic signed [23:0]     pid_result,
    output logic                   duty_wr,
    output logic [IDW-1:0]         duty_wr_id,
    output logic signed [23:0]     duty_wr_data,
    output logic                   busy,
    output logic [NUM_MOTORS-1:0]  fault,
    input  logic                   fault_clear,
    output logic                   overrun,
    output logic [7:0]             overrun_count
);

    localparam int PERIOD = CLOCK_FREQ / CONTROL_FREQ;
    localparam int CW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int TW     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_START,
        S_WAIT,
        S_WRITE
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [CW-1:0]          period_cnt;
    logic                   tick;
    logic [NUM_MOTORS-1:0]  mask;
    logic [IDW-1:0]         idx;
    logic [TW-1:0]          timer;
    logic signed [23:0]     data;
    logic                   last_idx;
    logic                   timeout_hit;
    logic                   round_go;
    logic [NUM_MOTORS-1:0]  fault_set;

    assign tick     = (period_cnt == CW'(PERIOD - 1));
    assign last_idx = (idx == IDW'(NUM_MOTORS - 1));
    assign round_go = tick && enable && (state == S_IDLE);

    // timer holds the number of WAIT cycles already spent; the last allowed
    // WAIT cycle is the one where timer reaches TIMEOUT-2, which puts the
    // timeout write exactly TIMEOUT cycles after pid_start.
    assign timeout_hit = (timer == TW'(TIMEOUT - 2));

    always_comb begin
        state_next = state;
        fault_set  = '0;
        case (state)
            S_IDLE:  if (round_go) state_next = S_SCAN;
            S_SCAN: begin
                if (mask[idx])     state_next = S_START;
                else if (last_idx) state_next = S_IDLE;
            end
            S_START: state_next = S_WAIT;
            S_WAIT: begin
                if (pid_done) begin
                    state_next = S_WRITE;
                end else if (timeout_hit) begin
                    state_next     = S_WRITE;
                    fault_set[idx] = 1'b1;
                end
            end
            S_WRITE: state_next = last_idx ? S_IDLE : S_SCAN;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state         <= S_IDLE;
            period_cnt    <= '0;
            mask          <= '0;
            idx           <= '0;
            timer         <= '0;
            data          <= '0;
            fault         <= '0;
            overrun_count <= '0;
        end else begin
            state      <= state_next;
            period_cnt <= tick ? '0 : period_cnt + 1'b1;
            fault      <= (fault_clear ? '0 : fault) | fault_set;
            if (overrun && (overrun_count != 8'hFF))
                overrun_count <= overrun_count + 8'd1;
            case (state)
                S_IDLE: begin
                    if (round_go) begin
                        mask <= motor_enable;
                        idx  <= '0;
                    end
                end
                S_SCAN: begin
                    if (!mask[idx] && !last_idx) idx <= idx + 1'b1;
                end
                S_START: timer <= '0;
                S_WAIT: begin
                    if (pid_done) begin
                        data <= pid_result;
                    end else begin
                        timer <= timer + 1'b1;
                        if (timeout_hit) data <= '0;
                    end
                end
                S_WRITE: begin
                    if (!last_idx) idx <= idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy         = (state != S_IDLE);
    assign overrun      = tick && busy;
    assign pid_start    = (state == S_START);
    assign pid_motor_id = (state == S_START || state == S_WAIT || state == S_WRITE) ? idx : '0;
    assign duty_wr      = (state == S_WRITE);
    assign duty_wr_id   = duty_wr ? idx : '0;
    assign duty_wr_data = duty_wr ? data : '0;

endmodule

// File: tb/tb_pid_round_robin_scheduler.sv
module tb_pid_round_robin_scheduler;

    localparam int NM     = 4;
    localparam int CF     = 1000;
    localparam int CTF    = 10;
    localparam int TO     = 32;
    localparam int PERIOD = CF / CTF;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [3:0]  motor_enable = '0;
    logic        pid_done = 1'b0;
    logic [23:0] pid_result = '0;
    logic        fault_clear = 1'b0;
    logic        pid_start;
    logic [1:0]  pid_motor_id;
    logic        duty_wr;
    logic [1:0]  duty_wr_id;
    logic [23:0] duty_wr_data;
    logic        busy;
    logic [3:0]  fault;
    logic        overrun;
    logic [7:0]  overrun_count;

    always #5 clk = ~clk;

    pid_round_robin_scheduler #(
        .NUM_MOTORS(NM), .CLOCK_FREQ(CF), .CONTROL_FREQ(CTF), .TIMEOUT(TO)
    ) dut (
        .CLK(clk), .reset(reset), .enable(enable), .motor_enable(motor_enable),
        .pid_start(pid_start), .pid_motor_id(pid_motor_id), .pid_done(pid_done),
        .pid_result(pid_result), .duty_wr(duty_wr), .duty_wr_id(duty_wr_id),
        .duty_wr_data(duty_wr_data), .busy(busy), .fault(fault),
        .fault_clear(fault_clear), .overrun(overrun), .overrun_count(overrun_count)
    );

    // ---------------- scoreboard bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;
    int c        = 0;  // cycles since reset release

    int          wr_c[$];
    int          wr_id[$];
    logic [23:0] wr_d[$];
    int          st_c[$];
    int          ov_c[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0h expected %0h", name, c, act, exp);
    endtask

    task automatic check_wr(input int i, input int cyc, input int id, input logic [23:0] d);
        n_checks++;
        if (i < wr_c.size() && wr_c[i] == cyc && wr_id[i] == id && wr_d[i] === d) n_pass++;
        else $display("FAIL write_log[%0d]: log_size=%0d got cycle=%0d id=%0d data=%0h expected cycle=%0d id=%0d data=%0h",
                      i, wr_c.size(), (i < wr_c.size()) ? wr_c[i] : -1,
                      (i < wr_c.size()) ? wr_id[i] : -1,
                      (i < wr_c.size()) ? wr_d[i] : 24'h0, cyc, id, d);
    endtask

    task automatic clear_logs();
        wr_c.delete(); wr_id.delete(); wr_d.delete(); st_c.delete(); ov_c.delete();
    endtask

    // ---------------- behavioural model + compare ----------------
    // The round is tracked as "which motor is being served and when its slot
    // began"; every expected output follows from cycle arithmetic on that.
    bit          in_round = 0;
    logic [3:0]  m_mask = '0;
    int          cur = 0;
    int          id_t0 = 0;
    int          done_at = -1;
    logic [23:0] m_data = '0;
    logic [3:0]  m_fault = '0;
    int          m_ocount = 0;
    bit          model_valid = 0;
    bit          post_reset = 0;

    always @(negedge clk) begin : model
        bit          tick, e_start, e_wr, e_busy, e_ovr, e_idv, adv;
        int          rel, wr_at;
        logic [1:0]  e_id;
        logic [23:0] e_data;
        logic [3:0]  f_next;

        tick    = ((c % PERIOD) == PERIOD - 1);
        e_start = 0; e_wr = 0; e_idv = 0; adv = 0;
        e_id    = '0; e_data = '0;
        e_busy  = in_round;
        e_ovr   = tick && in_round;
        f_next  = fault_clear ? 4'b0 : m_fault;

        if (in_round) begin
            rel = c - id_t0;
            if (rel == 0) begin
                if (!m_mask[cur]) adv = 1;
            end else if (rel == 1) begin
                e_start = 1; e_idv = 1; e_id = 2'(cur);
            end else begin
                e_idv = 1; e_id = 2'(cur);
                wr_at = (done_at >= 0) ? done_at + 1 : id_t0 + 1 + TO;
                if (c == wr_at) begin
                    e_wr = 1; e_data = (done_at >= 0) ? m_data : 24'h0; adv = 1;
                end else if (done_at < 0 && pid_done === 1'b1) begin
                    done_at = c; m_data = pid_result;
                end else if (done_at < 0 && c == id_t0 + TO) begin
                    f_next[cur] = 1'b1;
                end
            end
        end

        if (model_valid) begin
            check("pid_start", pid_start, e_start);
            check("duty_wr", duty_wr, e_wr);
            check("busy", busy, e_busy);
            check("overrun", overrun, e_ovr);
            check("fault", fault, m_fault);
            check("overrun_count", overrun_count, m_ocount);
            if (e_idv) check("pid_motor_id", pid_motor_id, e_id);
            if (e_wr) begin
                check("duty_wr_id", duty_wr_id, e_id);
                check("duty_wr_data", duty_wr_data, e_data);
            end
            if (post_reset)
                check("outputs_after_reset",
                      {pid_start, pid_motor_id, duty_wr, duty_wr_id, duty_wr_data,
                       busy, fault, overrun, overrun_count}, 64'h0);
        end

        if (duty_wr === 1'b1) begin
            wr_c.push_back(c); wr_id.push_back(int'(duty_wr_id)); wr_d.push_back(duty_wr_data);
        end
        if (pid_start === 1'b1) st_c.push_back(c);
        if (overrun === 1'b1) ov_c.push_back(c);

        post_reset = 0;
        if (reset === 1'b1) begin
            c = 0; in_round = 0; cur = 0; done_at = -1;
            m_fault = '0; m_ocount = 0;
            post_reset = 1; model_valid = 1;
        end else begin
            if (adv) begin
                cur++; id_t0 = c + 1; done_at = -1;
                if (cur == NM) in_round = 0;
            end
            if (e_ovr) begin
                if (m_ocount < 255) m_ocount++;
            end else if (tick && enable && !e_busy) begin
                in_round = 1; m_mask = motor_enable; cur = 0; id_t0 = c + 1; done_at = -1;
            end
            m_fault = f_next;
            c++;
        end
    end

    // ---------------- PID engine responder ----------------
    int          lat_lo = 3;
    int          lat_hi = 3;
    int          silent_id = -1;
    int          res_mode = 0;
    bit          stray_en = 0;
    int          resp_left = 0;
    logic [23:0] resp_val = '0;

    initial begin : responder
        forever begin
            @(negedge clk);
            if (pid_start === 1'b1) begin
                if (int'(pid_motor_id) == silent_id) begin
                    resp_left = 0;
                end else begin
                    resp_left = $urandom_range(lat_lo, lat_hi);
                    case (res_mode)
                        0:       resp_val = 24'h000100 + 24'(pid_motor_id);
                        1:       resp_val = 24'hFFFF00;
                        default: resp_val = 24'($urandom);
                    endcase
                end
            end
            @(posedge clk);
            #1;
            pid_done = 1'b0;
            if (resp_left > 0) begin
                resp_left--;
                if (resp_left == 0) begin
                    pid_done = 1'b1; pid_result = resp_val;
                end
            end else if (stray_en && $urandom_range(0, 20) == 0) begin
                pid_done = 1'b1; pid_result = 24'($urandom);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic run_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Leaves the bench at the first cycle after release (model cycle 0).
    task automatic do_reset();
        reset = 1'b1;
        run_cycles(2);
        reset = 1'b0;
        clear_logs();
    endtask

    task automatic setup(input int lo, input int hi, input int sil, input int rm, input bit st,
                         input logic [3:0] me);
        lat_lo = lo; lat_hi = hi; silent_id = sil; res_mode = rm; stray_en = st;
        motor_enable = me; enable = 1'b1; fault_clear = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin : stimulus
        @(posedge clk);
        #1;

        // all motors enabled, fixed latency 3
        setup(3, 3, -1, 0, 0, 4'b1111);
        do_reset();
        run_cycles(230);
        check_wr(0, 105, 0, 24'h000100);
        check_wr(1, 111, 1, 24'h000101);
        check_wr(2, 117, 2, 24'h000102);
        check_wr(3, 123, 3, 24'h000103);
        check_wr(4, 205, 0, 24'h000100);
        check("s1_first_start", st_c[0], 101);
        check("s1_no_overrun", ov_c.size(), 0);
        check("s1_busy_clear", busy, 0);

        // sparse mask
        setup(3, 3, -1, 0, 0, 4'b1010);
        do_reset();
        run_cycles(230);
        check("s2_write_count", wr_c.size(), 4);
        check_wr(0, 106, 1, 24'h000101);
        check_wr(1, 113, 3, 24'h000103);
        check_wr(2, 206, 1, 24'h000101);
        check_wr(3, 213, 3, 24'h000103);

        // silent motor 2 -> timeout
        setup(3, 3, 2, 0, 0, 4'b1111);
        do_reset();
        run_cycles(160);
        check_wr(2, 145, 2, 24'h0);
        check_wr(3, 151, 3, 24'h000103);
        check("s3_start_id2", st_c[2], 113);
        check("s3_fault_set", fault, 4'b0100);
        fault_clear = 1'b1;
        run_cycles(1);
        fault_clear = 1'b0;
        run_cycles(1);
        check("s3_fault_cleared", fault, 4'b0000);

        // long latency -> overrun
        setup(25, 25, -1, 0, 0, 4'b1111);
        do_reset();
        run_cycles(330);
        check("s4_overrun_count", overrun_count, 1);
        check("s4_overrun_pulses", ov_c.size(), 1);
        check("s4_overrun_cycle", ov_c[0], 199);
        check_wr(3, 211, 3, 24'h000103);
        check_wr(4, 327, 0, 24'h000100);
        check("s4_second_round_start", st_c[4], 301);

        // reset while waiting on motor 1
        setup(3, 3, -1, 0, 0, 4'b1111);
        do_reset();
        run_cycles(108);
        reset = 1'b1;
        run_cycles(2);
        check("s5_writes_before_reset", wr_c.size(), 1);
        reset = 1'b0;
        clear_logs();
        run_cycles(110);
        check("s5_first_start_after_release", st_c[0], 101);

        // negative result, stray dones
        setup(3, 3, -1, 1, 1, 4'b1111);
        do_reset();
        run_cycles(230);
        check("s6_write_count", wr_c.size(), 8);
        for (int i = 0; i < 4; i++)
            check_wr(i, 105 + 6 * i, i, 24'hFFFF00);

        // ticks with enable low are dropped quietly
        enable = 1'b0;
        stray_en = 0;
        clear_logs();
        run_cycles(150);
        check("s6_disabled_starts", st_c.size(), 0);
        check("s6_disabled_overruns", ov_c.size(), 0);

        // overrun counter saturation
        setup(24, 31, -1, 2, 0, 4'b1111);
        do_reset();
        run_cycles(52000);
        check("s7_overrun_saturated", overrun_count, 255);

        // randomized traffic, checked by the model every cycle
        setup(1, 40, -1, 2, 1, 4'(($urandom)));
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) enable = ~enable;
            if ($urandom_range(0, 79) == 0) motor_enable = 4'($urandom);
            if ($urandom_range(0, 99) == 0) silent_id = $urandom_range(0, 6) - 2;
            fault_clear = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 1499) == 0) begin
                fault_clear = 1'b0;
                reset = 1'b1;
                run_cycles(2);
                reset = 1'b0;
            end
            run_cycles(1);
        end
        fault_clear = 1'b0;
        run_cycles(5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
